// File: rtl/alu_cmd_queue_if.sv
// alu_cmd_queue_if: command, ALU-side and result handshake signals for alu_cmd_queue.
interface alu_cmd_queue_if #(
  parameter int W = 4,
  parameter int OPW = 3,
  parameter int DEPTH = 4
);
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [OPW-1:0] in_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [OPW-1:0] alu_op;
  logic [W-1:0] alu_y;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_y;
  logic [OPW-1:0] out_op;
  logic [$clog2(DEPTH):0] count;
`ifdef ALU_CMD_QUEUE_FLAGS_EN
  logic out_zero;
  logic out_neg;
`endif
  modport slave (
    input in_valid, in_a, in_b, in_op, alu_y, out_ready,
    output in_ready, alu_a, alu_b, alu_op, out_valid, out_y, out_op, count
`ifdef ALU_CMD_QUEUE_FLAGS_EN
    , output out_zero, out_neg
`endif
  );
  modport master (
    output in_valid, in_a, in_b, in_op, alu_y, out_ready,
    input in_ready, alu_a, alu_b, alu_op, out_valid, out_y, out_op, count
`ifdef ALU_CMD_QUEUE_FLAGS_EN
    , input out_zero, out_neg
`endif
  );
endinterface

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: FIFO-buffered issue stage for a combinational ALU with a registered result stage.
// Optional ALU_CMD_QUEUE_FLAGS_EN adds registered out_zero/out_neg result flags.
module alu_cmd_queue #(
  parameter int W = 4,
  parameter int OPW = 3,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  alu_cmd_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_a [DEPTH];
  logic [W-1:0] mem_b [DEPTH];
  logic [OPW-1:0] mem_op [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic push, cap;
  assign q.in_ready = cnt != (AW+1)'(DEPTH);
  assign q.count = cnt;
  assign push = q.in_valid && q.in_ready;
  assign cap = (cnt != '0) && (!q.out_valid || q.out_ready);
  assign q.alu_a = mem_a[rp];
  assign q.alu_b = mem_b[rp];
  assign q.alu_op = mem_op[rp];
  // storage is deliberately left unreset; only pointers and count define validity
  always_ff @(posedge clk)
    if (!rst && push) begin
      mem_a[wp] <= q.in_a;
      mem_b[wp] <= q.in_b;
      mem_op[wp] <= q.in_op;
    end
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      q.out_valid <= 1'b0;
      q.out_y <= '0;
      q.out_op <= '0;
`ifdef ALU_CMD_QUEUE_FLAGS_EN
      q.out_zero <= 1'b0;
      q.out_neg <= 1'b0;
`endif
    end else begin
      if (push) wp <= wp + AW'(1);
      if (cap) begin
        rp <= rp + AW'(1);
        q.out_valid <= 1'b1;
        q.out_y <= q.alu_y;
        q.out_op <= q.alu_op;
`ifdef ALU_CMD_QUEUE_FLAGS_EN
        q.out_zero <= q.alu_y == '0;
        q.out_neg <= q.alu_y[W-1];
`endif
      end else if (q.out_ready) q.out_valid <= 1'b0;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(cap);
    end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb_alu_cmd_queue: directed test-plan checks plus randomized traffic against a queue-based model.
module tb_alu_cmd_queue;
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } cmd_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  alu_cmd_queue_if #(.W(4), .OPW(3), .DEPTH(4)) qi ();
  alu_cmd_queue #(.W(4), .OPW(3), .DEPTH(4)) dut (.clk(clk), .rst(rst), .q(qi));
  always #5 clk = ~clk;
  function automatic logic [3:0] alu_f(logic [3:0] a, logic [3:0] b, logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return -a;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return {3'b000, $signed(a) < $signed(b)};
      default: return {3'b000, a == b};
    endcase
  endfunction
  assign qi.alu_y = alu_f(qi.alu_a, qi.alu_b, qi.alu_op);
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // reference: commands wait in a queue; one output slot holds the last result
  cmd_t mq[$];
  logic mv = 1'b0;
  logic [3:0] my = '0;
  logic [2:0] mo = '0;
  logic live = 1'b0;
  always @(negedge clk) begin
    cmd_t c;
    logic free, cap, push;
    if (live) begin
      chk("count", 32'(qi.count), 32'(mq.size()));
      chk("in_ready", 32'(qi.in_ready), 32'(mq.size() < 4));
      chk("out_valid", 32'(qi.out_valid), 32'(mv));
      if (mv) begin
        chk("out_y", 32'(qi.out_y), 32'(my));
        chk("out_op", 32'(qi.out_op), 32'(mo));
`ifdef ALU_CMD_QUEUE_FLAGS_EN
        chk("out_zero", 32'(qi.out_zero), 32'(my == 4'd0));
        chk("out_neg", 32'(qi.out_neg), 32'(my[3]));
`endif
      end
      if (mq.size() > 0) chk("head", 32'({qi.alu_a, qi.alu_b, qi.alu_op}), 32'(mq[0]));
    end
    if (rst) begin
      mq.delete();
      mv = 1'b0;
      my = '0;
      mo = '0;
      live = 1'b1;
    end else if (live) begin
      free = !mv || qi.out_ready;
      cap = mq.size() > 0 && free;
      push = qi.in_valid && mq.size() < 4;
      if (cap) begin
        c = mq.pop_front();
        my = alu_f(c.a, c.b, c.op);
        mo = c.op;
        mv = 1'b1;
      end else if (mv && qi.out_ready) mv = 1'b0;
      if (push) mq.push_back('{qi.in_a, qi.in_b, qi.in_op});
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cmd(logic [3:0] a, logic [3:0] b, logic [2:0] op);
    qi.in_valid = 1'b1;
    qi.in_a = a;
    qi.in_b = b;
    qi.in_op = op;
  endtask
  initial begin
    qi.in_valid = 1'b0;
    qi.in_a = '0;
    qi.in_b = '0;
    qi.in_op = '0;
    qi.out_ready = 1'b0;
    step();
    step();
    chk("rst_count", 32'(qi.count), 0);
    chk("rst_valid", 32'(qi.out_valid), 0);
    chk("rst_ready", 32'(qi.in_ready), 1);
    rst = 1'b0;
    qi.out_ready = 1'b1;
    cmd(4'd3, 4'd2, 3'd0);
    step();
    qi.in_valid = 1'b0;
    chk("lat_nv", 32'(qi.out_valid), 0);
    step();
    chk("lat_v", 32'(qi.out_valid), 1);
    chk("lat_y", 32'(qi.out_y), 5);
    chk("lat_op", 32'(qi.out_op), 0);
    chk("lat_cnt", 32'(qi.count), 0);
    step();
    qi.out_ready = 1'b0;
    cmd(4'd7, 4'd1, 3'd0);
    step();
    cmd(4'hD, 4'd2, 3'd1);
    step();
    chk("wrap_y", 32'(qi.out_y), 8);
    chk("wrap_cnt", 32'(qi.count), 1);
    chk("wrap_rdy", 32'(qi.in_ready), 1);
    cmd(4'd5, 4'd0, 3'd2);
    step();
    cmd(4'd2, 4'd4, 3'd6);
    step();
    cmd(4'hE, 4'hE, 3'd7);
    step();
    chk("full_cnt", 32'(qi.count), 4);
    chk("full_rdy", 32'(qi.in_ready), 0);
    cmd(4'd1, 4'd1, 3'd0);
    step();
    chk("fifth_cnt", 32'(qi.count), 4);
    chk("hold_y", 32'(qi.out_y), 8);
    chk("hold_op", 32'(qi.out_op), 0);
    qi.in_valid = 1'b0;
    qi.out_ready = 1'b1;
    step();
    chk("drain1", 32'(qi.out_y), 32'hB);
    chk("drain1_op", 32'(qi.out_op), 1);
    step();
    chk("drain2", 32'(qi.out_y), 32'hB);
    step();
    chk("drain3", 32'(qi.out_y), 1);
    step();
    chk("drain4", 32'(qi.out_y), 1);
    chk("drain4_op", 32'(qi.out_op), 7);
    chk("drain_cnt", 32'(qi.count), 0);
    step();
    chk("no_fifth", 32'(qi.out_valid), 0);
    qi.out_ready = 1'b0;
    cmd(4'd1, 4'd2, 3'd0);
    step();
    cmd(4'd2, 4'd2, 3'd0);
    step();
    cmd(4'd3, 4'd3, 3'd1);
    step();
    chk("two_cnt", 32'(qi.count), 2);
    qi.out_ready = 1'b1;
    cmd(4'd4, 4'd4, 3'd0);
    step();
    chk("pushcap_cnt", 32'(qi.count), 2);
    chk("pushcap_y", 32'(qi.out_y), 4);
    qi.out_ready = 1'b0;
    cmd(4'd5, 4'd5, 3'd0);
    step();
    chk("pre_rst_cnt", 32'(qi.count), 3);
    chk("pre_rst_v", 32'(qi.out_valid), 1);
    qi.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_cnt", 32'(qi.count), 0);
    chk("mid_rst_v", 32'(qi.out_valid), 0);
    chk("mid_rst_rdy", 32'(qi.in_ready), 1);
    chk("mid_rst_y", 32'(qi.out_y), 0);
    qi.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cmd(4'($urandom), 4'($urandom), 3'($urandom));
      step();
      chk("stream_cnt", 32'(qi.count <= 1), 1);
      if (i > 0) chk("stream_v", 32'(qi.out_valid), 1);
    end
    for (int i = 0; i < 3000; i++) begin
      int m;
      m = (i / 250) % 3;
      rst = $urandom_range(0, 299) == 0;
      qi.in_valid = m == 0 ? $urandom_range(0, 7) != 0 : $urandom_range(0, 1) == 1;
      qi.out_ready = m == 1 ? $urandom_range(0, 7) != 0 : $urandom_range(0, 2) == 0;
      qi.in_a = 4'($urandom);
      qi.in_b = 4'($urandom);
      qi.in_op = 3'($urandom);
      step();
    end
    rst = 1'b0;
    qi.in_valid = 1'b0;
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
